// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default constants for the fetch/data memory port arbiter.
//   arb_state_t : arbiter FSM states
//   port_id_t   : which pipeline port owns the current memory transaction
//   D_WORD      : machine word width used for address and data buses
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int D_WORD           = 64;
  localparam int MAX_STARVE_DEF   = 4;
  localparam int ACK_TIMEOUT_DEF  = 15;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA_BUSY = 2'd1,
    INST_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// ---------------------------------------------------------------------------
// mem_timeout_ctr
// Counts cycles spent waiting for a memory acknowledge.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the count (new transaction granted)
//   en         : a busy cycle passed without an acknowledge
//   expire     : this enabled cycle brings the count up to LIMIT; the owner
//                must abandon the transaction at this edge
// ---------------------------------------------------------------------------
module mem_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // Expiry is flagged on the edge that would make the count equal LIMIT,
  // so the requester sees exactly LIMIT busy cycles before the abort.
  assign expire = en && (cnt == CW'(LIMIT - 1));

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CW'(LIMIT))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port, variable-latency memory between instruction fetch
// and the data memory stage. Data requests win unless fetch has already been
// passed over MAX_STARVE times in a row. Transactions that never see mem_ack
// are aborted after ACK_TIMEOUT busy cycles and flagged on bus_err.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   if_req/if_addr              fetch read request (held until if_ready)
//   if_rdata/if_ready           fetch read data + one-cycle completion pulse
//   dm_read/dm_write/dm_addr/   data request (held until dm_ready)
//   dm_wdata
//   dm_rdata/dm_ready           data read value + one-cycle completion pulse
//   mem_req/mem_we/mem_addr/    memory request, held until mem_ack
//   mem_wdata
//   mem_rdata/mem_ack           memory response
//   stall_f/stall_m             pipeline hold while an access is outstanding
//   bus_err                     sticky: timeout or read+write collision
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = D_WORD,
  parameter int DATA_W      = D_WORD,
  parameter int MAX_STARVE  = MAX_STARVE_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  // data port
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  // pipeline control
  output logic              stall_f,
  output logic              stall_m,
  output logic              bus_err
);

  localparam int SW = $clog2(MAX_STARVE + 1);

  arb_state_t    state, next_state;
  port_id_t      busy_port;
  logic [SW-1:0] starve_cnt;
  logic          dm_pend;
  logic          grant_d, grant_i;
  logic          done, abort;
  logic          expire;

  assign dm_pend   = dm_read | dm_write;
  assign busy_port = (state == INST_BUSY) ? PORT_I : PORT_D;

  // Ready pulses come from flops, so the stalls release in the same cycle
  // the pulse is visible to the pipeline.
  assign stall_f = if_req  & ~if_ready;
  assign stall_m = dm_pend & ~dm_ready;

  mem_timeout_ctr #(
    .LIMIT (ACK_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (grant_d | grant_i),
    .en     ((state != IDLE) && !mem_ack),
    .expire (expire)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves a value held and no latch is inferred.
  always_comb begin
    next_state = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (dm_pend && ((starve_cnt < SW'(MAX_STARVE)) || !if_req)) begin
          grant_d    = 1'b1;
          next_state = DATA_BUSY;
        end else if (if_req) begin
          grant_i    = 1'b1;
          next_state = INST_BUSY;
        end
      end
      DATA_BUSY, INST_BUSY: begin
        // A real acknowledge always beats a timeout landing on the same edge.
        if (mem_ack) begin
          done       = 1'b1;
          next_state = IDLE;
        end else if (expire) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      if_ready   <= 1'b0;
      dm_rdata   <= '0;
      dm_ready   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state    <= next_state;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;

      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_write;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        // A simultaneous read+write goes out as a write but is flagged.
        if (dm_read && dm_write) bus_err <= 1'b1;
        if (if_req && (starve_cnt < SW'(MAX_STARVE))) starve_cnt <= starve_cnt + 1'b1;
      end

      if (grant_i) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        starve_cnt <= '0;
      end

      if (done || abort) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (abort) bus_err <= 1'b1;
        if (busy_port == PORT_I) begin
          if_ready <= 1'b1;
          if_rdata <= abort ? '0 : mem_rdata;
        end else begin
          dm_ready <= 1'b1;
          // mem_we still holds the granted direction on this edge; writes
          // leave the last read value in place.
          if (abort)        dm_rdata <= '0;
          else if (!mem_we) dm_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a transaction-level reference model of the arbiter.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MS = 4;
  localparam int AT = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, dm_read, dm_write, mem_ack;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_ready, dm_ready, mem_req, mem_we, stall_f, stall_m, bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_STARVE(MS), .ACK_TIMEOUT(AT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_f(stall_f), .stall_m(stall_m), .bus_err(bus_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int        edge_no = 0;
  bit        busy = 0;
  port_id_t  cur_port = PORT_D;
  bit        cur_wr = 0;
  int        grant_edge = 0;
  int        starve = 0;
  logic          exp_mem_req = 0, exp_mem_we = 0;
  logic [63:0]   exp_mem_addr = 0, exp_mem_wdata = 0, exp_if_rdata = 0, exp_dm_rdata = 0;
  logic          exp_if_ready = 0, exp_dm_ready = 0, exp_bus_err = 0;

  // memory responder / stimulus controls
  int          mem_lat = 0;
  int          ack_wait = 0;
  bit          rand_mode = 0;
  bit          spurious = 0;
  bit          fixed_rdata_en = 0;
  logic [63:0] fixed_rdata = 0;

  task automatic new_txn();
    ack_wait = 0;
    if (rand_mode) mem_lat = ($urandom_range(0, 39) == 0) ? -1 : int'($urandom_range(0, 3));
  endtask

  task automatic finish_txn(input bit aborted);
    busy        = 0;
    exp_mem_req = 0;
    exp_mem_we  = 0;
    if (aborted) exp_bus_err = 1;
    if (cur_port == PORT_I) begin
      exp_if_ready = 1;
      exp_if_rdata = aborted ? 64'h0 : mem_rdata;
    end else begin
      exp_dm_ready = 1;
      if (aborted)      exp_dm_rdata = 64'h0;
      else if (!cur_wr) exp_dm_rdata = mem_rdata;
    end
  endtask

  task automatic model_edge();
    edge_no++;
    exp_if_ready = 0;
    exp_dm_ready = 0;
    if (!rst_n) begin
      busy = 0; starve = 0;
      exp_mem_req = 0; exp_mem_we = 0; exp_mem_addr = 0; exp_mem_wdata = 0;
      exp_if_rdata = 0; exp_dm_rdata = 0; exp_bus_err = 0;
    end else if (busy) begin
      if (mem_ack)                           finish_txn(0);
      else if (edge_no - grant_edge == AT)   finish_txn(1);
    end else if ((dm_read || dm_write) && (starve < MS || !if_req)) begin
      busy = 1; cur_port = PORT_D; cur_wr = dm_write; grant_edge = edge_no;
      exp_mem_req = 1; exp_mem_we = dm_write; exp_mem_addr = dm_addr; exp_mem_wdata = dm_wdata;
      if (dm_read && dm_write) exp_bus_err = 1;
      if (if_req && starve < MS) starve++;
      new_txn();
    end else if (if_req) begin
      busy = 1; cur_port = PORT_I; cur_wr = 0; grant_edge = edge_no;
      exp_mem_req = 1; exp_mem_we = 0; exp_mem_addr = if_addr; exp_mem_wdata = 0;
      starve = 0;
      new_txn();
    end
  endtask

  task automatic compare_all();
    check("mem_req",   mem_req,   exp_mem_req);
    check("mem_we",    mem_we,    exp_mem_we);
    check("mem_addr",  mem_addr,  exp_mem_addr);
    check("mem_wdata", mem_wdata, exp_mem_wdata);
    check("if_ready",  if_ready,  exp_if_ready);
    check("dm_ready",  dm_ready,  exp_dm_ready);
    check("if_rdata",  if_rdata,  exp_if_rdata);
    check("dm_rdata",  dm_rdata,  exp_dm_rdata);
    check("bus_err",   bus_err,   exp_bus_err);
    check("stall_f",   stall_f,   if_req & ~exp_if_ready);
    check("stall_m",   stall_m,   (dm_read | dm_write) & ~exp_dm_ready);
  endtask

  task automatic drive_mem();
    if (exp_mem_req) begin
      mem_ack = (mem_lat >= 0) && (ack_wait == mem_lat);
      ack_wait++;
    end else begin
      mem_ack = spurious && ($urandom_range(0, 1) == 0);
    end
    mem_rdata = fixed_rdata_en ? fixed_rdata : {$urandom, $urandom};
  endtask

  task automatic drive_random();
    int r;
    rst_n = ($urandom_range(0, 299) != 0);
    if (exp_if_ready || !if_req) begin
      if_req  = ($urandom_range(0, 2) != 0);
      if_addr = {$urandom, $urandom};
    end else if ($urandom_range(0, 49) == 0) begin
      if_req = 0;
    end
    if (exp_dm_ready || !(dm_read || dm_write)) begin
      r        = int'($urandom_range(0, 39));
      dm_read  = (r < 16) || (r == 32);
      dm_write = (r >= 16 && r < 33);
      dm_addr  = {$urandom, $urandom};
      dm_wdata = {$urandom, $urandom};
    end else if ($urandom_range(0, 49) == 0) begin
      dm_read = 0; dm_write = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    drive_mem();
    if (rand_mode) drive_random();
  endtask

  task automatic wait_ready(input string tag, input bit data_port, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(data_port ? exp_dm_ready : exp_if_ready) && n < budget);
    check({tag, "_ready"}, data_port ? dm_ready : if_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt;
    int ngr;
    bit gr_d [0:15];
    logic prev_req;

    rst_n = 0; if_req = 0; if_addr = 0; dm_read = 0; dm_write = 0;
    dm_addr = 0; dm_wdata = 0; mem_ack = 0; mem_rdata = 0;

    // reset state
    tick(); tick();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    rst_n = 1;
    tick();

    // single fetch, ack two cycles after mem_req
    fixed_rdata_en = 1; fixed_rdata = 64'h30F4; mem_lat = 2;
    if_req = 1; if_addr = 64'h100;
    tick();
    check("f_we",   mem_we,   1'b0);
    check("f_addr", mem_addr, 64'h100);
    wait_ready("f", 0, 10, n);
    check("f_lat",   n, 3);
    check("f_rdata", if_rdata, 64'h30F4);
    if_req = 0;
    tick();
    check("f_stall", stall_f, 1'b0);
    fixed_rdata_en = 0;

    // data write, same-cycle ack
    mem_lat = 0;
    dm_write = 1; dm_addr = 64'h200; dm_wdata = 64'hDEAD;
    tick();
    check("w_we",    mem_we,    1'b1);
    check("w_wdata", mem_wdata, 64'hDEAD);
    check("w_addr",  mem_addr,  64'h200);
    wait_ready("w", 1, 10, n);
    check("w_lat",   n + 1, 2);
    check("w_rdata", dm_rdata, 64'h0);
    dm_write = 0;
    tick();

    // timeout: no ack ever
    mem_lat = -1;
    dm_read = 1; dm_addr = 64'h300;
    n = 0; cnt = 0;
    do begin
      tick();
      n++;
      if (mem_req) cnt++;
    end while (!exp_dm_ready && n < 40);
    dm_read = 0;
    check("to_req_cycles", cnt, AT);
    check("to_ready", dm_ready, 1'b1);
    check("to_rdata", dm_rdata, 64'h0);
    check("to_err",   bus_err,  1'b1);
    repeat (3) tick();
    check("to_err_sticky", bus_err, 1'b1);

    // reset in the middle of a data transaction
    dm_read = 1; dm_addr = 64'h400;
    tick(); tick();
    rst_n = 0; dm_read = 0;
    tick();
    check("rm_req",   mem_req,  1'b0);
    check("rm_ready", dm_ready, 1'b0);
    check("rm_err",   bus_err,  1'b0);
    rst_n = 1; spurious = 1;
    repeat (4) tick();
    check("rm_late_ack", dm_ready, 1'b0);
    spurious = 0;

    // illegal read+write
    mem_lat = 1;
    dm_read = 1; dm_write = 1; dm_addr = 64'h500; dm_wdata = 64'h55;
    tick();
    check("il_we",  mem_we,  1'b1);
    check("il_err", bus_err, 1'b1);
    wait_ready("il", 1, 10, n);
    dm_read = 0; dm_write = 0;
    tick();

    // reset, then contention with both requests held and immediate acks
    rst_n = 0; tick(); rst_n = 1; tick();
    mem_lat = 0;
    if_req = 1; if_addr = 64'h1000;
    dm_read = 1; dm_addr = 64'h2000;
    ngr = 0; prev_req = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_req && !prev_req && ngr < 16) begin
        gr_d[ngr] = (mem_addr == 64'h2000);
        ngr++;
      end
      prev_req = mem_req;
    end
    check("cont_grants", ngr >= 10, 1'b1);
    for (int i = 0; i < 10; i++)
      check($sformatf("cont_grant%0d", i), gr_d[i], (i % 5) != 4);
    if_req = 0; dm_read = 0;
    repeat (4) tick();

    // randomized traffic against the model
    rand_mode = 1; spurious = 1;
    repeat (2500) tick();
    rand_mode = 0; spurious = 0;
    rst_n = 1; if_req = 0; dm_read = 0; dm_write = 0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
